// File: rtl/regbank_wr_arbiter_pkg.sv
// Shared definitions for the register-bank write-port arbiter.
package regbank_wr_arbiter_pkg;

    // Requester indices; these values are also the bank MS1/MS0 source encoding.
    localparam logic [1:0] SRC_ALU = 2'd0;
    localparam logic [1:0] SRC_REG = 2'd1;
    localparam logic [1:0] SRC_IMM = 2'd2;
    localparam logic [1:0] SRC_CLR = 2'd3;

    // 3-bit register index into the 8-entry bank.
    typedef logic [2:0] reg_idx_t;

    // 2-bit requester index / priority pointer.
    typedef logic [1:0] src_idx_t;

    // One-hot grant vector for a requester index.
    function automatic logic [3:0] onehot4(input src_idx_t idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/regbank_wr_arbiter_rr_pick4.sv
// Combinational 4-way round-robin picker: first eligible index at or above ptr, wrapping.
module rr_pick4
    import regbank_wr_arbiter_pkg::*;
(
    input  logic [3:0] eligible_i,
    input  src_idx_t   ptr_i,
    output logic       any_o,
    output src_idx_t   winner_o
);

    src_idx_t idx;

    // Scan offsets from farthest to nearest so the nearest eligible index is assigned last.
    always_comb begin
        any_o    = 1'b0;
        winner_o = ptr_i;
        idx      = '0;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr_i + src_idx_t'(k);
            if (eligible_i[idx]) begin
                any_o    = 1'b1;
                winner_o = idx;
            end
        end
    end

endmodule

// File: rtl/regbank_wr_arbiter.sv
// Round-robin arbiter sharing the register bank's single write port between
// ALU, register-move, immediate-load and clear requesters. All outputs are
// registered so the bank's (~E | CLK) gated clocks stay glitch-free.
module regbank_wr_arbiter
    import regbank_wr_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int NREG = 8
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [NREQ-1:0] req_i,
    input  reg_idx_t        dst0_i,
    input  reg_idx_t        dst1_i,
    input  reg_idx_t        dst2_i,
    input  reg_idx_t        dst3_i,
    input  logic            stall_i,
    output logic [NREQ-1:0] gnt_o,
    output logic            ms1_o,
    output logic            ms0_o,
    output logic            rs2_o,
    output logic            rs1_o,
    output logic            rs0_o,
    output logic            e_o,
    output logic [NREG-1:0] written_o
);

    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            e_q, e_d;
    src_idx_t        ms_q, ms_d;
    reg_idx_t        rs_q, rs_d;
    src_idx_t        ptr_q, ptr_d;
    logic [NREG-1:0] written_q, written_d;

    logic [NREQ-1:0] eligible;
    logic            any;
    src_idx_t        winner;
    reg_idx_t        dst_a [NREQ];

    assign dst_a[SRC_ALU] = dst0_i;
    assign dst_a[SRC_REG] = dst1_i;
    assign dst_a[SRC_IMM] = dst2_i;
    assign dst_a[SRC_CLR] = dst3_i;

    // The requester being granted this cycle is masked so a same-edge REQ drop cannot double-grant.
    assign eligible = req_i & ~gnt_q;

    rr_pick4 u_pick (
        .eligible_i (eligible),
        .ptr_i      (ptr_q),
        .any_o      (any),
        .winner_o   (winner)
    );

    // Next-state: grant the picked requester unless stalled; select lines hold when idle.
    always_comb begin
        gnt_d     = '0;
        e_d       = 1'b0;
        ms_d      = ms_q;
        rs_d      = rs_q;
        ptr_d     = ptr_q;
        written_d = written_q;
        if (!stall_i && any) begin
            gnt_d = onehot4(winner);
            e_d   = 1'b1;
            ms_d  = winner;
            rs_d  = dst_a[winner];
            ptr_d = winner + 2'd1;
        end
        if (e_q) begin
            written_d[rs_q] = 1'b1;
        end
    end

    // State and output registers; reset aborts any in-flight write immediately.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            gnt_q     <= '0;
            e_q       <= 1'b0;
            ms_q      <= '0;
            rs_q      <= '0;
            ptr_q     <= '0;
            written_q <= '0;
        end else begin
            gnt_q     <= gnt_d;
            e_q       <= e_d;
            ms_q      <= ms_d;
            rs_q      <= rs_d;
            ptr_q     <= ptr_d;
            written_q <= written_d;
        end
    end

    assign gnt_o     = gnt_q;
    assign e_o       = e_q;
    assign ms1_o     = ms_q[1];
    assign ms0_o     = ms_q[0];
    assign rs2_o     = rs_q[2];
    assign rs1_o     = rs_q[1];
    assign rs0_o     = rs_q[0];
    assign written_o = written_q;

endmodule

// File: tb/tb_regbank_wr_arbiter.sv
// Self-checking bench for regbank_wr_arbiter: directed vector table, a
// reset-during-write sequence, and randomized traffic against a reference model.
module tb_regbank_wr_arbiter;

    localparam logic [7:0] ALU_DATA = 8'd123;
    localparam logic [7:0] REG_DATA = 8'h55;
    localparam logic [7:0] IMM_DATA = 8'hA7;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       stall;
    logic [2:0] dst [4];
    logic [3:0] gnt;
    logic       ms1, ms0, rs2, rs1, rs0, e;
    logic [7:0] written;
    logic [1:0] ms;
    logic [2:0] rs;

    int n_cmp  = 0;
    int n_fail = 0;

    assign ms = {ms1, ms0};
    assign rs = {rs2, rs1, rs0};

    always #5 clk = ~clk;

    regbank_wr_arbiter #(.NREQ(4), .NREG(8)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .req_i     (req),
        .dst0_i    (dst[0]),
        .dst1_i    (dst[1]),
        .dst2_i    (dst[2]),
        .dst3_i    (dst[3]),
        .stall_i   (stall),
        .gnt_o     (gnt),
        .ms1_o     (ms1),
        .ms0_o     (ms0),
        .rs2_o     (rs2),
        .rs1_o     (rs1),
        .rs0_o     (rs0),
        .e_o       (e),
        .written_o (written)
    );

    // Model of the 8x8 bank: captures the selected source on the edge ending an E cycle.
    logic [7:0] bank [8];
    bit         bank_ok = 1'b0;
    always @(posedge clk) begin
        if (!bank_ok) begin
            for (int i = 0; i < 8; i++) bank[i] <= 8'hEE;
            bank_ok <= 1'b1;
        end else if (e) begin
            case (ms)
                2'd0:    bank[rs] <= ALU_DATA;
                2'd1:    bank[rs] <= REG_DATA;
                2'd2:    bank[rs] <= IMM_DATA;
                default: bank[rs] <= 8'h00;
            endcase
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] g, input logic ee,
                           input logic [1:0] m, input logic [2:0] r, input logic [7:0] w);
        chk({tag, ".gnt"},     32'(gnt),     32'(g));
        chk({tag, ".e"},       32'(e),       32'(ee));
        chk({tag, ".ms"},      32'(ms),      32'(m));
        chk({tag, ".rs"},      32'(rs),      32'(r));
        chk({tag, ".written"}, 32'(written), 32'(w));
    endtask

    typedef struct {
        bit         rst;
        logic [3:0] req;
        bit         stall;
        logic [11:0] dst;   // {DST3, DST2, DST1, DST0}
        logic [3:0] g;
        bit         e;
        logic [1:0] ms;
        logic [2:0] rs;
        logic [7:0] wr;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(bit r, logic [3:0] q, bit s, logic [11:0] d,
                                logic [3:0] g, bit ee, logic [1:0] m, logic [2:0] rr,
                                logic [7:0] w);
        vec_t v;
        v.rst = r; v.req = q; v.stall = s; v.dst = d;
        v.g = g; v.e = ee; v.ms = m; v.rs = rr; v.wr = w;
        return v;
    endfunction

    // Reference model state: plain round-robin rules.
    int         m_ptr;
    logic [3:0] m_gnt;
    logic       m_e;
    logic [1:0] m_ms;
    logic [2:0] m_rs;
    logic [7:0] m_wr;

    task automatic model_reset();
        m_ptr = 0; m_gnt = 4'd0; m_e = 1'b0; m_ms = 2'd0; m_rs = 3'd0; m_wr = 8'd0;
    endtask

    task automatic model_step(input logic [3:0] r, input bit s, input logic [11:0] d);
        int w;
        w = -1;
        if (m_e) m_wr = m_wr | (8'd1 << m_rs);
        if (!s) begin
            for (int k = 0; k < 4; k++) begin
                int idx;
                idx = (m_ptr + k) % 4;
                if (r[idx] && !m_gnt[idx]) begin
                    w = idx;
                    break;
                end
            end
        end
        if (w < 0) begin
            m_gnt = 4'd0;
            m_e   = 1'b0;
        end else begin
            m_gnt = 4'(1 << w);
            m_e   = 1'b1;
            m_ms  = 2'(w);
            m_rs  = d[w*3 +: 3];
            m_ptr = (w + 1) % 4;
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish by 200000");
        $fatal(1);
    end

    initial begin
        logic [11:0] dr;
        rst = 1'b1; req = 4'd0; stall = 1'b0;
        for (int i = 0; i < 4; i++) dst[i] = 3'd0;

        // Reset then idle
        vt.push_back(mk(1, 4'h0, 0, 12'h000, 4'h0, 0, 2'd0, 3'd0, 8'h00));
        for (int i = 0; i < 5; i++)
            vt.push_back(mk(0, 4'h0, 0, 12'h000, 4'h0, 0, 2'd0, 3'd0, 8'h00));
        // Single ALU write to R5
        vt.push_back(mk(0, 4'h1, 0, 12'h005, 4'h1, 1, 2'd0, 3'd5, 8'h00));
        vt.push_back(mk(0, 4'h0, 0, 12'h005, 4'h0, 0, 2'd0, 3'd5, 8'h20));
        // Full contention, DST0=1 DST1=6 DST2=7 DST3=3
        vt.push_back(mk(1, 4'h0, 0, 12'h7F1, 4'h0, 0, 2'd0, 3'd0, 8'h00));
        vt.push_back(mk(0, 4'hF, 0, 12'h7F1, 4'h1, 1, 2'd0, 3'd1, 8'h00));
        vt.push_back(mk(0, 4'hF, 0, 12'h7F1, 4'h2, 1, 2'd1, 3'd6, 8'h02));
        vt.push_back(mk(0, 4'hF, 0, 12'h7F1, 4'h4, 1, 2'd2, 3'd7, 8'h42));
        vt.push_back(mk(0, 4'hF, 0, 12'h7F1, 4'h8, 1, 2'd3, 3'd3, 8'hC2));
        vt.push_back(mk(0, 4'hF, 0, 12'h7F1, 4'h1, 1, 2'd0, 3'd1, 8'hCA));
        // Held single IMM requester, DST2=4: alternate-cycle grants
        vt.push_back(mk(1, 4'h0, 0, 12'h100, 4'h0, 0, 2'd0, 3'd0, 8'h00));
        for (int i = 0; i < 3; i++) begin
            vt.push_back(mk(0, 4'h4, 0, 12'h100, 4'h4, 1, 2'd2, 3'd4, (i == 0) ? 8'h00 : 8'h10));
            vt.push_back(mk(0, 4'h4, 0, 12'h100, 4'h0, 0, 2'd2, 3'd4, 8'h10));
        end
        // Stall with ALU+REG requesting, DST0=2 DST1=5
        vt.push_back(mk(1, 4'h0, 0, 12'h02A, 4'h0, 0, 2'd0, 3'd0, 8'h00));
        for (int i = 0; i < 3; i++)
            vt.push_back(mk(0, 4'h3, 1, 12'h02A, 4'h0, 0, 2'd0, 3'd0, 8'h00));
        vt.push_back(mk(0, 4'h3, 0, 12'h02A, 4'h1, 1, 2'd0, 3'd2, 8'h00));
        vt.push_back(mk(0, 4'h3, 0, 12'h02A, 4'h2, 1, 2'd1, 3'd5, 8'h04));
        vt.push_back(mk(0, 4'h0, 0, 12'h02A, 4'h0, 0, 2'd1, 3'd5, 8'h24));

        foreach (vt[i]) begin
            for (int k = 0; k < 4; k++) dst[k] = vt[i].dst[k*3 +: 3];
            req   = vt[i].req;
            stall = vt[i].stall;
            if (vt[i].rst) begin
                rst = 1'b1;
                #1;
                chk_all($sformatf("vec%0d", i), vt[i].g, vt[i].e, vt[i].ms, vt[i].rs, vt[i].wr);
                @(posedge clk);
                #1;
                rst = 1'b0;
            end else begin
                @(posedge clk);
                #1;
                chk_all($sformatf("vec%0d", i), vt[i].g, vt[i].e, vt[i].ms, vt[i].rs, vt[i].wr);
            end
            if (i == 7)  chk("bank_r5_alu", 32'(bank[5]), 32'(ALU_DATA));
            if (i == 13) begin
                chk("bank_r3_clr", 32'(bank[3]), 32'd0);
                chk("bank_r6_reg", 32'(bank[6]), 32'(REG_DATA));
            end
        end

        // Reset arriving in the middle of a REG grant cycle targeting R0
        req = 4'h0; stall = 1'b0;
        pulse_reset();
        dst[1] = 3'd0;
        req = 4'h2;
        @(posedge clk);
        #1;
        chk("midrst_pre.gnt", 32'(gnt), 32'h2);
        chk("midrst_pre.e",   32'(e),   32'h1);
        #2;
        rst = 1'b1;
        #1;
        chk_all("midrst_async", 4'h0, 1'b0, 2'd0, 3'd0, 8'h00);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_bank_r0", 32'(bank[0]), 32'hEE);
        chk("midrst_written", 32'(written), 32'h00);
        req = 4'hF;
        @(posedge clk);
        #1;
        chk("midrst_ptr0.gnt", 32'(gnt), 32'h1);

        // Randomized traffic against the reference model
        req = 4'h0; stall = 1'b0;
        pulse_reset();
        model_reset();
        for (int it = 0; it < 600; it++) begin
            req   = ((it % 60) < 12) ? 4'hF : 4'($urandom_range(0, 15));
            stall = ($urandom_range(0, 3) == 0);
            for (int k = 0; k < 4; k++) dst[k] = 3'($urandom_range(0, 7));
            dr = {dst[3], dst[2], dst[1], dst[0]};
            model_step(req, stall, dr);
            @(posedge clk);
            #1;
            chk_all($sformatf("rnd%0d", it), m_gnt, m_e, m_ms, m_rs, m_wr);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
